// File: rtl/mult_acc_pkg.sv
// Shared types and constants for the product accumulator.
// The optional saturation feature is selected by the MULT_ACC_SAT_EN macro.
package mult_acc_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam int PROD_W    = 16;
    localparam int DEF_TERMS = 8;
    localparam int DEF_ACC_W = 18;

endpackage

// File: rtl/mult_acc_add.sv
// Combinational accumulator adder: ACC_W + 16 bit unsigned add with carry out.
// With MULT_ACC_SAT_EN defined, a carry clamps the sum to all ones; otherwise it wraps.
module mult_acc_add
    import mult_acc_pkg::*;
#(
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [PROD_W-1:0] prod,
    output logic [ACC_W-1:0]  sum,
    output logic              carry
);

    logic [ACC_W:0] raw;

    function automatic logic [ACC_W-1:0] saturate(input logic [ACC_W:0] v);
`ifdef MULT_ACC_SAT_EN
        return v[ACC_W] ? {ACC_W{1'b1}} : v[ACC_W-1:0];
`else
        return v[ACC_W-1:0];
`endif
    endfunction

    // Product is unsigned: zero-extend, never sign-extend.
    assign raw   = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod};
    assign carry = raw[ACC_W];
    assign sum   = saturate(raw);

endmodule

// File: rtl/mult_accumulator.sv
// Sums TERMS consecutive multiplier products (or fewer, on prod_last) and holds each
// result on a valid/ready port, stalling upstream meanwhile. Saturation: MULT_ACC_SAT_EN.
module mult_accumulator
    import mult_acc_pkg::*;
#(
    parameter int TERMS = DEF_TERMS,
    parameter int ACC_W = DEF_ACC_W,
    parameter int CNT_W = $clog2(TERMS + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [PROD_W-1:0] prod,
    input  logic              prod_valid,
    input  logic              prod_last,
    output logic              prod_ready,
    output logic [ACC_W-1:0]  acc_out,
    output logic [CNT_W-1:0]  acc_terms,
    output logic              acc_ovf,
    output logic              acc_valid,
    input  logic              acc_ready
);

    state_t            state;
    state_t            state_next;
    logic [ACC_W-1:0]  acc;
    logic [CNT_W-1:0]  cnt;
    logic              ovf;
    logic [ACC_W-1:0]  sum;
    logic              carry;
    logic              xfer;
    logic              close;
    logic              release_res;

    mult_acc_add #(.ACC_W(ACC_W)) u_add (
        .acc   (acc),
        .prod  (prod),
        .sum   (sum),
        .carry (carry)
    );

    assign xfer        = prod_valid & prod_ready;
    // prod_last and the TERMS-th transfer coincide into one close.
    assign close       = xfer & (prod_last | (cnt == CNT_W'(TERMS - 1)));
    assign release_res = (state == HOLD) & acc_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ACCUM;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ACCUM:   if (close)       state_next = HOLD;
            HOLD:    if (release_res) state_next = ACCUM;
            default: state_next = ACCUM;
        endcase
    end

    always_comb begin
        prod_ready = 1'b0;
        acc_valid  = 1'b0;
        case (state)
            ACCUM:   prod_ready = ~reset;
            HOLD:    acc_valid  = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            acc_out   <= '0;
            acc_terms <= '0;
            acc_ovf   <= 1'b0;
        end else if (xfer) begin
            acc <= sum;
            ovf <= ovf | carry;
            if (close) begin
                acc_out   <= sum;
                acc_terms <= cnt + CNT_W'(1);
                acc_ovf   <= ovf | carry;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end else if (release_res) begin
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
        end
    end

endmodule
